// File: rtl/hft_pkg.sv
// Shared types and constants for the arbitrage front end.
// Operand widths follow the Container's vertex/weight encoding.
package hft_pkg;

  localparam int unsigned PRED_WIDTH      = 4;
  localparam int unsigned WEIGHT_WIDTH    = 15;
  localparam int unsigned TIMEOUT_DEFAULT = 65535;

  typedef logic [PRED_WIDTH:0]   pred_t;
  typedef logic [WEIGHT_WIDTH:0] weight_t;

  typedef struct packed {
    pred_t   src;
    pred_t   dst;
    weight_t e;
  } upd_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RUN      = 3'd2,
    COMPLETE = 3'd3,
    ABORT    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/update_fifo.sv
// Synchronous update FIFO with registered level and registered not-full.
module update_fifo
  import hft_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  upd_t          i_data,
  output upd_t          o_head_c,
  output logic [LW-1:0] o_level,
  output logic          o_full_n
);

  localparam int unsigned AW = $clog2(DEPTH);

  upd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_full_n;
  logic          w_push;
  logic          w_pop;
  logic [LW-1:0] w_level_nxt;

  assign w_push      = i_push & r_full_n;
  assign w_pop       = i_pop & (r_level != LW'(0));
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_level  = r_level;
  assign o_full_n = r_full_n;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full_n <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level  <= w_level_nxt;
      r_full_n <= (w_level_nxt < LW'(DEPTH));
    end
  end

endmodule

// File: rtl/update_sequencer.sv
// Queues host edge-weight updates and runs the Container once per update,
// sequencing its reset and aborting through a watchdog if it hangs.
module update_sequencer
  import hft_pkg::*;
#(
  parameter  int unsigned DEPTH   = 8,
  parameter  int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  localparam int unsigned LW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          upd_valid,
  output logic          upd_ready,
  input  pred_t         upd_src,
  input  pred_t         upd_dst,
  input  weight_t       upd_e,
  output pred_t         u_src,
  output pred_t         u_dst,
  output weight_t       u_e,
  output logic          container_reset,
  input  logic          container_done,
  input  logic          clear_err,
  output logic          busy,
  output logic          run_done,
  output logic [15:0]   run_count,
  output logic          timeout_err,
  output logic [LW-1:0] fifo_level
);

  localparam int unsigned WDW = 16;

  seq_state_t     r_state;
  seq_state_t     w_state_nxt;
  logic           w_pop;
  upd_t           w_head;
  upd_t           w_in;
  logic [WDW-1:0] r_wdog;

  assign w_in = '{src: upd_src, dst: upd_dst, e: upd_e};

  update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_push   (upd_valid),
    .i_pop    (w_pop),
    .i_data   (w_in),
    .o_head_c (w_head),
    .o_level  (fifo_level),
    .o_full_n (upd_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Done outranks the watchdog; illegal encodings fall back to IDLE.
  always_comb begin
    w_state_nxt = IDLE;
    w_pop       = 1'b0;
    case (r_state)
      IDLE:     w_state_nxt = (fifo_level != LW'(0)) ? LOAD : IDLE;
      LOAD: begin
        w_state_nxt = RUN;
        w_pop       = 1'b1;
      end
      RUN: begin
        if (container_done)                   w_state_nxt = COMPLETE;
        else if (r_wdog == WDW'(TIMEOUT - 1)) w_state_nxt = ABORT;
        else                                  w_state_nxt = RUN;
      end
      COMPLETE: w_state_nxt = (fifo_level != LW'(0)) ? LOAD : IDLE;
      ABORT:    w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Outputs decode the next state so they are valid in the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_src           <= '0;
      u_dst           <= '0;
      u_e             <= '0;
      container_reset <= 1'b1;
      busy            <= 1'b0;
      run_done        <= 1'b0;
      run_count       <= '0;
      timeout_err     <= 1'b0;
      r_wdog          <= '0;
    end else begin
      container_reset <= (w_state_nxt != RUN);
      busy            <= (w_state_nxt == RUN);
      run_done        <= (w_state_nxt == COMPLETE);
      if (w_state_nxt == COMPLETE) run_count <= run_count + 16'd1;
      if (r_state == LOAD) begin
        u_src  <= w_head.src;
        u_dst  <= w_head.dst;
        u_e    <= w_head.e;
        r_wdog <= '0;
      end else if (r_state == RUN) begin
        r_wdog <= r_wdog + WDW'(1);
      end
      if (w_state_nxt == ABORT) timeout_err <= 1'b1;
      else if (clear_err)       timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_update_sequencer.sv
// Directed bench for update_sequencer: instance A runs the functional and
// stall/reset scenarios, instance B uses a short watchdog.
module tb_update_sequencer;
  import hft_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic          rst, upd_valid, upd_ready, container_reset, container_done;
  logic          clear_err, busy, run_done, timeout_err;
  pred_t         upd_src, upd_dst, u_src, u_dst;
  weight_t       upd_e, u_e;
  logic [15:0]   run_count;
  logic [LW-1:0] fifo_level;

  // Instance B signals
  logic          rst_b, valid_b, ready_b, creset_b, done_b;
  logic          clear_b, busy_b, run_done_b, terr_b;
  pred_t         src_b, dst_b, usrc_b, udst_b;
  weight_t       e_b, ue_b;
  logic [15:0]   count_b;
  logic [LW-1:0] level_b;

  update_sequencer #(.DEPTH(DEPTH)) dut_a (
    .clk(clk), .reset(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_src(upd_src), .upd_dst(upd_dst), .upd_e(upd_e),
    .u_src(u_src), .u_dst(u_dst), .u_e(u_e),
    .container_reset(container_reset), .container_done(container_done),
    .clear_err(clear_err), .busy(busy), .run_done(run_done),
    .run_count(run_count), .timeout_err(timeout_err), .fifo_level(fifo_level)
  );

  update_sequencer #(.DEPTH(DEPTH), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(rst_b), .upd_valid(valid_b), .upd_ready(ready_b),
    .upd_src(src_b), .upd_dst(dst_b), .upd_e(e_b),
    .u_src(usrc_b), .u_dst(udst_b), .u_e(ue_b),
    .container_reset(creset_b), .container_done(done_b),
    .clear_err(clear_b), .busy(busy_b), .run_done(run_done_b),
    .run_count(count_b), .timeout_err(terr_b), .fifo_level(level_b)
  );

  // Container model for A: done rises done_delay cycles after reset falls.
  int   low_cnt;
  int   done_delay;
  logic stall, force_done;
  always @(posedge clk or posedge rst) begin
    if (rst)                  low_cnt <= 0;
    else if (container_reset) low_cnt <= 0;
    else                      low_cnt <= low_cnt + 1;
  end
  assign container_done = force_done | (!stall & !container_reset & (low_cnt >= done_delay));

  upd_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input pred_t s, input pred_t d, input weight_t e, output bit acc);
    @(negedge clk);
    upd_valid = 1'b1;
    upd_src   = s;
    upd_dst   = d;
    upd_e     = e;
    acc       = upd_ready;
    @(posedge clk);
    if (acc) sb.push_back('{src: s, dst: d, e: e});
  endtask

  // Issue monitor: order via scoreboard, operand stability, reset gap.
  upd_t held;
  bit   prev_busy;
  int   gap;
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      gap       = 0;
    end else begin
      if (busy && !prev_busy) begin
        chk("reset_gap_ge2", 32'(gap >= 2), 32'd1);
        if (sb.size() == 0) chk("unexpected_issue", 32'd1, 32'd0);
        else chk("issue_order", 32'({u_src, u_dst, u_e}), 32'(sb.pop_front()));
        held = '{src: u_src, dst: u_dst, e: u_e};
      end else if (busy && prev_busy) begin
        chk("u_stable", 32'({u_src, u_dst, u_e}), 32'(held));
      end
      if (container_reset) gap = gap + 1;
      else                 gap = 0;
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit acc;
    int acc_n;
    rst = 1'b1; rst_b = 1'b1;
    upd_valid = 0; upd_src = '0; upd_dst = '0; upd_e = '0; clear_err = 0;
    valid_b = 0; src_b = '0; dst_b = '0; e_b = '0; clear_b = 0; done_b = 0;
    stall = 0; force_done = 0; done_delay = 20;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(upd_ready), 32'd0);
    chk("rst_creset", 32'(container_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_run_done", 32'(run_done), 32'd0);
    chk("rst_count", 32'(run_count), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_u", 32'({u_src, u_dst, u_e}), 32'd0);
    rst = 1'b0; rst_b = 1'b0;

    // Single update, done 20 cycles after container_reset falls
    push_a(pred_t'(3), pred_t'(5), weight_t'(-7), acc);
    chk("t1_accept", 32'(acc), 32'd1);
    @(negedge clk); upd_valid = 1'b0;
    chk("t1_level_e0", 32'(fifo_level), 32'd1);
    chk("t1_creset_e0", 32'(container_reset), 32'd1);
    @(negedge clk);
    chk("t1_creset_load", 32'(container_reset), 32'd1);
    chk("t1_busy_load", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_creset_run", 32'(container_reset), 32'd0);
    chk("t1_busy_run", 32'(busy), 32'd1);
    chk("t1_u_src", 32'(u_src), 32'd3);
    chk("t1_u_dst", 32'(u_dst), 32'd5);
    chk("t1_u_e", 32'(u_e), 32'(weight_t'(-7)));
    chk("t1_level_run", 32'(fifo_level), 32'd0);
    repeat (20) @(negedge clk);
    chk("t1_busy_e22", 32'(busy), 32'd1);
    chk("t1_no_done_e22", 32'(run_done), 32'd0);
    @(negedge clk);
    chk("t1_run_done", 32'(run_done), 32'd1);
    chk("t1_count", 32'(run_count), 32'd1);
    chk("t1_creset_cmp", 32'(container_reset), 32'd1);
    @(negedge clk);
    chk("t1_done_pulse", 32'(run_done), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_creset", 32'(container_reset), 32'd1);

    // Stalled container: fill FIFO behind one running update
    stall = 1'b1; done_delay = 3; acc_n = 0;
    for (int i = 0; i < 12; i++) begin
      push_a(pred_t'(i), pred_t'(i + 1), weight_t'(i * 100 - 250), acc);
      if (acc) acc_n++;
    end
    @(negedge clk); upd_valid = 1'b0;
    chk("t2_accepted", 32'(acc_n), 32'd9);
    chk("t2_level_full", 32'(fifo_level), 32'd8);
    chk("t2_ready_low", 32'(upd_ready), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    for (int c = 0; c < 400 && run_count != 16'd10; c++) @(negedge clk);
    chk("t2_count", 32'(run_count), 32'd10);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_level_empty", 32'(fifo_level), 32'd0);

    // Async reset mid-run with 3 queued
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push_a(pred_t'(i + 7), pred_t'(i + 2), weight_t'(i + 40), acc);
    @(negedge clk); upd_valid = 1'b0;
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_level", 32'(fifo_level), 32'd3);
    rst = 1'b1;
    #1;
    chk("t5_creset_async", 32'(container_reset), 32'd1);
    chk("t5_level_flush", 32'(fifo_level), 32'd0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    sb.delete();
    @(negedge clk); rst = 1'b0; stall = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_no_issue", 32'(busy), 32'd0);
    chk("t5_creset_held", 32'(container_reset), 32'd1);
    chk("t5_count_rst", 32'(run_count), 32'd0);

    // Done held high while idle
    force_done = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("t6_no_run_done", 32'(run_done), 32'd0);
    end
    chk("t6_count", 32'(run_count), 32'd0);
    force_done = 1'b0;

    // Watchdog abort on B (TIMEOUT=16)
    @(negedge clk); valid_b = 1'b1; src_b = pred_t'(9); dst_b = pred_t'(1); e_b = weight_t'(12);
    chk("t3_ready", 32'(ready_b), 32'd1);
    @(negedge clk); valid_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_busy", 32'(busy_b), 32'd1);
    chk("t3_u_src", 32'(usrc_b), 32'd9);
    repeat (15) @(negedge clk);
    chk("t3_busy_last", 32'(busy_b), 32'd1);
    chk("t3_terr_pre", 32'(terr_b), 32'd0);
    @(negedge clk);
    chk("t3_abort_creset", 32'(creset_b), 32'd1);
    chk("t3_terr", 32'(terr_b), 32'd1);
    chk("t3_no_run_done", 32'(run_done_b), 32'd0);
    chk("t3_count", 32'(count_b), 32'd0);
    @(negedge clk);
    chk("t3_terr_sticky", 32'(terr_b), 32'd1);
    clear_b = 1'b1;
    @(negedge clk); clear_b = 1'b0;
    chk("t3_terr_clear", 32'(terr_b), 32'd0);

    // Done coincides with watchdog expiry on B
    @(negedge clk); valid_b = 1'b1; src_b = pred_t'(2); dst_b = pred_t'(4); e_b = weight_t'(-1);
    @(negedge clk); valid_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_busy", 32'(busy_b), 32'd1);
    repeat (15) @(negedge clk);
    done_b = 1'b1;
    @(negedge clk);
    chk("t4_run_done", 32'(run_done_b), 32'd1);
    chk("t4_count", 32'(count_b), 32'd1);
    chk("t4_terr", 32'(terr_b), 32'd0);
    done_b = 1'b0;
    @(negedge clk);
    chk("t4_terr_after", 32'(terr_b), 32'd0);
    chk("t4_pulse_end", 32'(run_done_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
